// File: rtl/bicubic_phase_gen.sv
// Output-raster walker for the bicubic scaler: maps each output pixel (centre-aligned)
// to a source integer position and 8-bit blend per axis, streamed on valid/ready.
module bicubic_phase_gen #(
    parameter int CW = 12,
    parameter int SW = 16,
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cfg_src_w,
    input  logic [CW-1:0] cfg_src_h,
    input  logic [CW-1:0] cfg_out_w,
    input  logic [CW-1:0] cfg_out_h,
    input  logic [SW-1:0] cfg_step_x,
    input  logic [SW-1:0] cfg_step_y,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [CW-1:0] o_x_int,
    output logic [CW-1:0] o_y_int,
    output logic [8:0]    o_x_blend,
    output logic [8:0]    o_y_blend,
    output logic          o_sof,
    output logic          o_sol,
    output logic          o_eol,
    output logic          o_eof,
    output logic          busy,
    output logic          done
);

    // Stream contract: a beat transfers on a rising edge where o_valid & o_ready;
    // while o_valid & !o_ready every output holds, and o_valid never drops unaccepted.
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
    logic [CW-1:0] out_w_q, out_w_d, out_h_q, out_h_d;
    logic [SW-1:0] step_x_q, step_x_d, step_y_q, step_y_d;
    logic [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [CW-1:0] cnt_x_q, cnt_x_d, cnt_y_q, cnt_y_d;
    logic          valid_q, valid_d, done_q, done_d;
    logic [CW-1:0] x_int_q, x_int_d, y_int_q, y_int_d;
    logic [7:0]    x_bl_q, x_bl_d, y_bl_q, y_bl_d;
    logic          sof_q, sof_d, sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;
    logic [AW-1:0] init_x, init_y;
    logic [CW+7:0] map_x, map_y;
    logic          load_out, eol_n;

    // Negative accumulators clamp to the first pixel, anything past the edge to the last.
    function automatic logic [CW+7:0] map_axis(input logic [AW-1:0] acc, input logic [CW-1:0] src);
        logic [AW-10:0] ipart;
        logic [AW-10:0] lim;
        ipart = acc[AW-2:8];
        lim   = {{(AW-9-CW){1'b0}}, src - CW'(1)};
        if (acc[AW-1])
            return '0;
        else if (ipart >= lim)
            return {src - CW'(1), 8'd0};
        else
            return {acc[CW+7:8], acc[7:0]};
    endfunction

    always_comb begin
        state_d  = state_q;
        src_w_d  = src_w_q;
        src_h_d  = src_h_q;
        out_w_d  = out_w_q;
        out_h_d  = out_h_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        cnt_x_d  = cnt_x_q;
        cnt_y_d  = cnt_y_q;
        valid_d  = valid_q;
        x_int_d  = x_int_q;
        y_int_d  = y_int_q;
        x_bl_d   = x_bl_q;
        y_bl_d   = y_bl_q;
        sof_d    = sof_q;
        sol_d    = sol_q;
        eol_d    = eol_q;
        eof_d    = eof_q;
        done_d   = 1'b0;
        load_out = 1'b0;
        // (step>>1) - 0.5 pixel in Q.8: centre-aligned position of output pixel 0.
        init_x   = {{(AW-SW+1){1'b0}}, step_x_q[SW-1:1]} - AW'(128);
        init_y   = {{(AW-SW+1){1'b0}}, step_y_q[SW-1:1]} - AW'(128);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_w_d  = cfg_src_w;
                    src_h_d  = cfg_src_h;
                    out_w_d  = cfg_out_w;
                    out_h_d  = cfg_out_h;
                    step_x_d = cfg_step_x;
                    step_y_d = cfg_step_y;
                    if (cfg_out_w != '0 && cfg_out_h != '0)
                        state_d = ST_LOAD;
                    else
                        done_d = 1'b1;
                end
            end
            ST_LOAD: begin
                acc_x_d = init_x;
                acc_y_d = init_y;
                cnt_x_d = '0;
                cnt_y_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!valid_q) begin
                    valid_d  = 1'b1;
                    load_out = 1'b1;
                end else if (o_ready) begin
                    if (eof_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        sof_d   = 1'b0;
                        sol_d   = 1'b0;
                        eol_d   = 1'b0;
                        eof_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        load_out = 1'b1;
                        if (cnt_x_q < out_w_q - CW'(1)) begin
                            cnt_x_d = cnt_x_q + CW'(1);
                            acc_x_d = acc_x_q + {{(AW-SW){1'b0}}, step_x_q};
                        end else begin
                            cnt_x_d = '0;
                            acc_x_d = init_x;
                            cnt_y_d = cnt_y_q + CW'(1);
                            acc_y_d = acc_y_q + {{(AW-SW){1'b0}}, step_y_q};
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the coordinate that will be current after this edge.
        map_x = map_axis(acc_x_d, src_w_q);
        map_y = map_axis(acc_y_d, src_h_q);
        eol_n = (cnt_x_d == out_w_q - CW'(1));
        if (load_out) begin
            x_int_d = map_x[CW+7:8];
            x_bl_d  = map_x[7:0];
            y_int_d = map_y[CW+7:8];
            y_bl_d  = map_y[7:0];
            sof_d   = (cnt_x_d == '0) && (cnt_y_d == '0);
            sol_d   = (cnt_x_d == '0);
            eol_d   = eol_n;
            eof_d   = eol_n && (cnt_y_d == out_h_q - CW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            src_w_q  <= '0;
            src_h_q  <= '0;
            out_w_q  <= '0;
            out_h_q  <= '0;
            step_x_q <= '0;
            step_y_q <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            cnt_x_q  <= '0;
            cnt_y_q  <= '0;
            valid_q  <= 1'b0;
            x_int_q  <= '0;
            y_int_q  <= '0;
            x_bl_q   <= '0;
            y_bl_q   <= '0;
            sof_q    <= 1'b0;
            sol_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_w_q  <= src_w_d;
            src_h_q  <= src_h_d;
            out_w_q  <= out_w_d;
            out_h_q  <= out_h_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            cnt_x_q  <= cnt_x_d;
            cnt_y_q  <= cnt_y_d;
            valid_q  <= valid_d;
            x_int_q  <= x_int_d;
            y_int_q  <= y_int_d;
            x_bl_q   <= x_bl_d;
            y_bl_q   <= y_bl_d;
            sof_q    <= sof_d;
            sol_q    <= sol_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            done_q   <= done_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_x_int   = x_int_q;
    assign o_y_int   = y_int_q;
    assign o_x_blend = {1'b0, x_bl_q};
    assign o_y_blend = {1'b0, y_bl_q};
    assign o_sof     = sof_q;
    assign o_sol     = sol_q;
    assign o_eol     = eol_q;
    assign o_eof     = eof_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_bicubic_phase_gen.sv
// Directed bench for bicubic_phase_gen: hand-computed beat sequences for upscale,
// 1:1, downscale, backpressure, zero-size start, start-while-running and reset mid-frame.
module tb_bicubic_phase_gen;

    localparam int CW = 12;
    localparam int SW = 16;
    localparam int AW = 30;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] cfg_src_w, cfg_src_h, cfg_out_w, cfg_out_h;
    logic [SW-1:0] cfg_step_x, cfg_step_y;
    logic          o_valid, o_ready;
    logic [CW-1:0] o_x_int, o_y_int;
    logic [8:0]    o_x_blend, o_y_blend;
    logic          o_sof, o_sol, o_eol, o_eof, busy, done;

    bicubic_phase_gen #(.CW(CW), .SW(SW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
        .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h),
        .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_x_int(o_x_int), .o_y_int(o_y_int),
        .o_x_blend(o_x_blend), .o_y_blend(o_y_blend),
        .o_sof(o_sof), .o_sol(o_sol), .o_eol(o_eol), .o_eof(o_eof),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [45:0] beat_q[$];
    int          first_valid, done_cycle, last_beat, stall_errs, busy_errs;
    logic        valid_at_done;

    int up_x[8] = '{0, 0, 0, 1, 1, 2, 2, 3};
    int up_b[8] = '{0, 64, 192, 64, 192, 64, 192, 0};

    function automatic logic [45:0] mk(input int xi, input int xb, input int yi, input int yb,
                                       input bit sof, input bit sol, input bit eol, input bit eof);
        return {12'(xi), 9'(xb), 12'(yi), 9'(yb), sof, sol, eol, eof};
    endfunction

    function automatic logic [45:0] got_beat(input int i);
        if (i < beat_q.size()) return beat_q[i];
        return 'x;
    endfunction

    task automatic set_cfg(input int sw, input int sh, input int ow, input int oh,
                           input int stx, input int sty);
        cfg_src_w  = 12'(sw);
        cfg_src_h  = 12'(sh);
        cfg_out_w  = 12'(ow);
        cfg_out_h  = 12'(oh);
        cfg_step_x = 16'(stx);
        cfg_step_y = 16'(sty);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the start edge (cycle 0); collects accepted beats until done.
    task automatic run_frame(input int max_cycles, input bit rand_ready, input int start_at);
        logic [46:0] snap, prev_snap;
        bit          prev_stall;
        beat_q.delete();
        first_valid   = -1;
        done_cycle    = -1;
        last_beat     = -1;
        stall_errs    = 0;
        busy_errs     = 0;
        valid_at_done = 1'bx;
        prev_stall    = 1'b0;
        prev_snap     = '0;
        for (int c = 0; c < max_cycles; c++) begin
            snap = {o_valid, o_x_int, o_x_blend, o_y_int, o_y_blend, o_sof, o_sol, o_eol, o_eof};
            if (prev_stall && snap !== prev_snap) stall_errs++;
            if (done) begin
                done_cycle    = c;
                valid_at_done = o_valid;
                if (busy) busy_errs++;
                break;
            end
            if (!busy) busy_errs++;
            if (first_valid < 0 && o_valid) first_valid = c;
            start   = (c == start_at);
            o_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && o_ready) begin
                beat_q.push_back({o_x_int, o_x_blend, o_y_int, o_y_blend, o_sof, o_sol, o_eol, o_eof});
                last_beat = c;
            end
            prev_stall = o_valid && !o_ready;
            prev_snap  = snap;
            @(negedge clk);
        end
        start   = 1'b0;
        o_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        o_ready = 1'b1;
        set_cfg(4, 1, 8, 1, 128, 256);
        repeat (3) @(negedge clk);
        total++;
        if ({o_valid, busy, done} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000", {o_valid, busy, done});
        end
        total++;
        if ({o_x_int, o_x_blend, o_y_int, o_y_blend, o_sof, o_sol, o_eol, o_eof} !== 46'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0",
                            {o_x_int, o_x_blend, o_y_int, o_y_blend, o_sof, o_sol, o_eol, o_eof});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_upscale;
        set_cfg(4, 1, 8, 1, 128, 256);
        pulse_start();
        run_frame(40, 1'b0, -1);
        total++;
        if (beat_q.size() != 8) begin
            bad++; $display("FAIL up_count got=%0d exp=8", beat_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_beat(i) !== mk(up_x[i], up_b[i], 0, 0, i == 0, i == 0, i == 7, i == 7)) begin
                bad++; $display("FAIL up_beat%0d got=%h exp=%h", i, got_beat(i),
                                mk(up_x[i], up_b[i], 0, 0, i == 0, i == 0, i == 7, i == 7));
            end
        end
        total++;
        if (first_valid != 2) begin
            bad++; $display("FAIL up_latency got=%0d exp=2", first_valid);
        end
    endtask

    task automatic test_one_to_one;
        set_cfg(5, 3, 5, 3, 256, 256);
        pulse_start();
        run_frame(60, 1'b0, -1);
        total++;
        if (beat_q.size() != 15) begin
            bad++; $display("FAIL one_count got=%0d exp=15", beat_q.size());
        end
        for (int i = 0; i < 15; i++) begin
            total++;
            if (got_beat(i) !== mk(i % 5, 0, i / 5, 0, i == 0, i % 5 == 0, i % 5 == 4, i == 14)) begin
                bad++; $display("FAIL one_beat%0d got=%h exp=%h", i, got_beat(i),
                                mk(i % 5, 0, i / 5, 0, i == 0, i % 5 == 0, i % 5 == 4, i == 14));
            end
        end
        total++;
        if (first_valid != 2) begin
            bad++; $display("FAIL one_latency got=%0d exp=2", first_valid);
        end
        total++;
        if (done_cycle != 17) begin
            bad++; $display("FAIL one_done_cycle got=%0d exp=17", done_cycle);
        end
        total++;
        if (valid_at_done !== 1'b0 || busy_errs != 0) begin
            bad++; $display("FAIL one_done_ctrl got valid=%b busy_errs=%0d exp valid=0 busy_errs=0",
                            valid_at_done, busy_errs);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL one_done_width got=%b exp=0", done);
        end
    endtask

    task automatic test_downscale;
        set_cfg(8, 8, 4, 4, 512, 512);
        pulse_start();
        run_frame(60, 1'b0, -1);
        total++;
        if (beat_q.size() != 16) begin
            bad++; $display("FAIL down_count got=%0d exp=16", beat_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got_beat(i) !== mk(2 * (i % 4), 128, 2 * (i / 4), 128,
                                   i == 0, i % 4 == 0, i % 4 == 3, i == 15)) begin
                bad++; $display("FAIL down_beat%0d got=%h exp=%h", i, got_beat(i),
                                mk(2 * (i % 4), 128, 2 * (i / 4), 128, i == 0, i % 4 == 0, i % 4 == 3, i == 15));
            end
        end
    endtask

    task automatic test_backpressure;
        set_cfg(4, 1, 8, 1, 128, 256);
        pulse_start();
        run_frame(300, 1'b1, -1);
        total++;
        if (beat_q.size() != 8) begin
            bad++; $display("FAIL bp_count got=%0d exp=8", beat_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_beat(i) !== mk(up_x[i], up_b[i], 0, 0, i == 0, i == 0, i == 7, i == 7)) begin
                bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_beat(i),
                                mk(up_x[i], up_b[i], 0, 0, i == 0, i == 0, i == 7, i == 7));
            end
        end
        total++;
        if (stall_errs != 0) begin
            bad++; $display("FAIL bp_stable got=%0d exp=0 changes while stalled", stall_errs);
        end
        total++;
        if (done_cycle != last_beat + 1) begin
            bad++; $display("FAIL bp_done got=%0d exp=%0d", done_cycle, last_beat + 1);
        end
    endtask

    task automatic test_zero_size;
        int seen_valid;
        set_cfg(4, 1, 0, 1, 128, 256);
        pulse_start();
        total++;
        if ({done, busy, o_valid} !== 3'b100) begin
            bad++; $display("FAIL zero_w_done got=%b exp=100", {done, busy, o_valid});
        end
        seen_valid = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_valid || busy || done) seen_valid++;
        end
        total++;
        if (seen_valid != 0) begin
            bad++; $display("FAIL zero_w_quiet got=%0d exp=0 active cycles", seen_valid);
        end
        set_cfg(4, 1, 8, 0, 128, 256);
        pulse_start();
        total++;
        if ({done, busy, o_valid} !== 3'b100) begin
            bad++; $display("FAIL zero_h_done got=%b exp=100", {done, busy, o_valid});
        end
        @(negedge clk);
    endtask

    task automatic test_start_during_run;
        set_cfg(5, 3, 5, 3, 256, 256);
        pulse_start();
        set_cfg(4, 1, 8, 1, 128, 256);
        run_frame(60, 1'b0, 6);
        total++;
        if (beat_q.size() != 15) begin
            bad++; $display("FAIL sdr_count got=%0d exp=15", beat_q.size());
        end
        for (int i = 0; i < 15; i++) begin
            total++;
            if (got_beat(i) !== mk(i % 5, 0, i / 5, 0, i == 0, i % 5 == 0, i % 5 == 4, i == 14)) begin
                bad++; $display("FAIL sdr_beat%0d got=%h exp=%h", i, got_beat(i),
                                mk(i % 5, 0, i / 5, 0, i == 0, i % 5 == 0, i % 5 == 4, i == 14));
            end
        end
        total++;
        if (done_cycle != 17) begin
            bad++; $display("FAIL sdr_done got=%0d exp=17", done_cycle);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL sdr_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        set_cfg(4, 1, 8, 1, 128, 256);
        pulse_start();
        o_ready = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if ({o_valid, o_x_int, o_x_blend} !== {1'b1, 12'd1, 9'd192}) begin
            bad++; $display("FAIL rst_beat5 got=%b/%0d/%0d exp=1/1/192", o_valid, o_x_int, o_x_blend);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, busy, done, o_x_int, o_x_blend, o_y_int, o_y_blend,
             o_sof, o_sol, o_eol, o_eof} !== 49'd0) begin
            bad++; $display("FAIL rst_async got valid=%b busy=%b x=%0d/%0d exp all 0",
                            o_valid, busy, o_x_int, o_x_blend);
        end
        repeat (2) @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL rst_no_done got=%b exp=0", done);
        end
        rst_n = 1'b1;
        pulse_start();
        run_frame(40, 1'b0, -1);
        total++;
        if (beat_q.size() != 8) begin
            bad++; $display("FAIL rerun_count got=%0d exp=8", beat_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got_beat(i) !== mk(up_x[i], up_b[i], 0, 0, i == 0, i == 0, i == 7, i == 7)) begin
                bad++; $display("FAIL rerun_beat%0d got=%h exp=%h", i, got_beat(i),
                                mk(up_x[i], up_b[i], 0, 0, i == 0, i == 0, i == 7, i == 7));
            end
        end
    endtask

    initial begin
        test_reset();
        test_upscale();
        test_one_to_one();
        test_downscale();
        test_backpressure();
        test_zero_size();
        test_start_during_run();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bicubic_phase_gen.md
# bicubic_phase_gen

Output-pixel coordinate and phase generator for the bicubic scaler. It walks the output raster and maps each output pixel, centre-aligned, to a source integer position and an 8-bit fractional blend. It runs in X and Y and presents the results on a valid/ready stream. The stream feeds the bicubic weight units, which take a 9-bit blend where 256 = 1.0, and the tap-fetch logic.

## Interface
- CW, default 12: coordinate / dimension width.
- SW, default 16: step width, unsigned Q8.8.
- AW, default 30: signed accumulator width, Q(AW-9).8.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle frame start; ignored unless in IDLE.
- cfg_src_w, cfg_src_h  in  CW each  source dimensions; each ≥ 1.
- cfg_out_w, cfg_out_h  in  CW each  output dimensions.
- cfg_step_x, cfg_step_y  in  SW each  source/output ratio, Q8.8.
- o_valid  out  1  coordinate valid.
- o_ready  in  1  downstream accept.
- o_x_int, o_y_int  out  CW each  source integer position.
- o_x_blend, o_y_blend  out  9 each  {1'b0, frac[7:0]}, range 0..255.
- o_sof, o_sol, o_eol, o_eof  out  1 each  start of frame, start of line, end of line, end of frame; qualified by o_valid.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse after the last handshake of a frame, or after a rejected zero-size start.

## Operation
- The config inputs are sampled into internal registers on the start cycle. Config changes during a frame have no effect.
- State machine:
  - IDLE –start & out_w≠0 & out_h≠0→ LOAD.
  - IDLE –start with out_w==0 or out_h==0→ IDLE, with done pulsed the next cycle.
  - LOAD → RUN, unconditionally.
  - RUN –handshake on the o_eof beat→ IDLE, with done pulsed.
- LOAD initialises the accumulators:
  - acc_x = acc_y = (step>>1) − 128, sign-extended to AW. This is the centre alignment src = (dst+0.5)·step − 0.5.
  - Counters cnt_x = cnt_y = 0.
- Mapping, applied per axis to produce the outputs:
  - acc < 0 → int = 0, blend = 0.
  - acc[AW-2:8] ≥ src−1 → int = src−1, blend = 0.
  - Otherwise → int = acc[CW+7:8], blend = {1'b0, acc[7:0]}.
- On a handshake (o_valid & o_ready) in RUN:
  - If cnt_x < out_w−1: cnt_x++, acc_x += step_x.
  - Else (end of line): cnt_x = 0, acc_x = init_x, cnt_y++, acc_y += step_y.
- Flags:
  - sof = (cnt_x==0 & cnt_y==0).
  - sol = (cnt_x==0).
  - eol = (cnt_x==out_w−1).
  - eof = eol & (cnt_y==out_h−1).
- Arithmetic:
  - Step is zero-extended before addition.
  - The accumulator never wraps for out·step ≤ 2^(AW−1). Config beyond that bound is not supported.
- Y output is constant across a line.

## Timing
- Reset: state IDLE; o_valid, busy, done, all flags = 0; o_x_int, o_y_int, o_x_blend, o_y_blend = 0; accumulators and counters = 0.
- Latency: start sampled at edge k → LOAD after k → o_valid = 1 with the first coordinate after edge k+2 (RUN).
- Outputs are registered.
- With o_ready held high, one coordinate is issued per cycle and there are no bubbles at line boundaries.
- Backpressure: while o_valid & !o_ready, all outputs hold stable.
- o_valid drops on the cycle after the eof handshake. done = 1 for exactly that cycle, and busy = 0 from that cycle.
- start is ignored in LOAD and RUN. start in the same cycle as done (state IDLE) is accepted.
- rst_n asserted mid-frame → immediate IDLE, outputs at reset values, no done pulse.
- 1×1 output: the single beat carries sof = sol = eol = eof = 1.

## Test plan
- **2× upscale, X axis:** src_w = 4, out_w = 8, step_x = 128, o_ready held 1 → (x_int, x_blend) = (0,0), (0,64), (0,192), (1,64), (1,192), (2,64), (2,192), (3,0); eol only on the 8th beat.
- **1:1:** src = out = 5×3, steps = 256 → x_int = 0..4 and y_int = 0..2, all blends 0; 15 beats; sof on beat 1, eof on beat 15; done on the cycle after beat 15; first o_valid two cycles after start.
- **2:1 downscale:** src = 8×8, out = 4×4, steps = 512 → x_int = 0, 2, 4, 6 with blend 128 each; y follows the same pattern per line; 16 beats total.
- **Backpressure:** toggle o_ready randomly in the 2× case → beat sequence identical to the first scenario, outputs stable while stalled, no lost or duplicated beats.
- **Edge controls:**
  - start with out_w = 0 → no o_valid, done after 1 cycle, busy stays 0.
  - start during RUN → ignored, frame completes normally.
- **Reset mid-frame:** rst_n low at beat 5 → all outputs 0 immediately; a subsequent start reruns the frame from sof with the first scenario's values.
